// File: rtl/bin2bcd3_seq_pkg.sv
// -----------------------------------------------------------------------------
// bin2bcd3_seq_pkg
// Shared definitions for the sequential binary-to-BCD converter:
//   DIGIT_W       width of one BCD digit
//   BCD_MAX       largest value that fits in three decimal digits
//   THOUS_W       width of the thousands field of the BCD scratch register
//   SCRATCH_W     total BCD scratch width (thousands bit plus three nibbles)
//   state_t       converter FSM states IDLE / SHIFT / COMMIT
//   add3_adjust() double-dabble nibble correction (>=5 -> +3)
// -----------------------------------------------------------------------------
package bin2bcd3_seq_pkg;

  localparam int DIGIT_W   = 4;
  localparam int BCD_MAX   = 999;
  localparam int THOUS_W   = 1;
  localparam int SCRATCH_W = THOUS_W + 3 * DIGIT_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  // A nibble of 5..9 becomes 8..12 so the following left shift carries
  // correctly into the next decimal digit. Inputs never exceed 9 in a valid
  // conversion, so the sum stays within 4 bits.
  function automatic logic [DIGIT_W-1:0] add3_adjust(input logic [DIGIT_W-1:0] nib);
    logic [DIGIT_W-1:0] res;
    if (nib >= DIGIT_W'(5)) begin
      res = nib + DIGIT_W'(3);
    end else begin
      res = nib;
    end
    return res;
  endfunction

endpackage

// File: rtl/bin2bcd3_seq_bcd_add3.sv
// -----------------------------------------------------------------------------
// bcd_add3
// Combinational double-dabble nibble adjust: outputs din+3 when din >= 5,
// otherwise passes din through.
// Ports:
//   din   in  4  BCD nibble before the shift
//   dout  out 4  corrected nibble, ready to be shifted left
// -----------------------------------------------------------------------------
module bcd_add3
  import bin2bcd3_seq_pkg::*;
(
  input  logic [DIGIT_W-1:0] din,
  output logic [DIGIT_W-1:0] dout
);

  always_comb begin
    dout = add3_adjust(din);
  end

endmodule

// File: rtl/bin2bcd3_seq.sv
// -----------------------------------------------------------------------------
// bin2bcd3_seq
// Sequential binary-to-BCD converter (shift-add-3, one bit per clock) feeding
// a three-digit display. Digits and ovf change only at the end of a
// conversion so a renderer never samples a half-converted value.
//
// Parameters:
//   BIN_W   width of the binary input, legal 4..10 (default 10)
// Ports:
//   clk     in   1      system clock, posedge
//   rst_n   in   1      synchronous active-low reset
//   start   in   1      conversion request, sampled only while idle
//   bin     in   BIN_W  unsigned value captured on the accepted start
//   busy    out  1      high from the cycle after accept until done
//   done    out  1      one-cycle pulse when new digits are valid
//   a2      out  4      hundreds digit
//   a1      out  4      tens digit
//   a0      out  4      ones digit
//   ovf     out  1      last converted value exceeded 999
//
// Build option:
//   BIN2BCD3_SATURATE_EN  when defined, an overflowing value shows 9/9/9;
//                         otherwise it shows the low three digits.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for start; outputs hold the last committed result
// SHIFT  | one adjust-and-shift step per clock, BIN_W steps in total
// COMMIT | copy scratch into the output digits, pulse done
// -----------------------------------------------------------------------------
module bin2bcd3_seq
  import bin2bcd3_seq_pkg::*;
#(
  parameter int BIN_W = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [BIN_W-1:0]   bin,
  output logic               busy,
  output logic               done,
  output logic [DIGIT_W-1:0] a2,
  output logic [DIGIT_W-1:0] a1,
  output logic [DIGIT_W-1:0] a0,
  output logic               ovf
);

  localparam int CNT_W = $clog2(BIN_W + 1);

  state_t                 state;
  logic [BIN_W-1:0]       shreg;
  logic [SCRATCH_W-1:0]   scratch;
  logic [CNT_W-1:0]       count;

  logic [DIGIT_W-1:0]     adj2;
  logic [DIGIT_W-1:0]     adj1;
  logic [DIGIT_W-1:0]     adj0;
  logic                   thous;

  bcd_add3 u_add3_hund (
    .din  (scratch[3*DIGIT_W-1:2*DIGIT_W]),
    .dout (adj2)
  );

  bcd_add3 u_add3_tens (
    .din  (scratch[2*DIGIT_W-1:DIGIT_W]),
    .dout (adj1)
  );

  bcd_add3 u_add3_ones (
    .din  (scratch[DIGIT_W-1:0]),
    .dout (adj0)
  );

  assign thous = scratch[SCRATCH_W-1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      shreg   <= '0;
      scratch <= '0;
      count   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      a2      <= '0;
      a1      <= '0;
      a0      <= '0;
      ovf     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            shreg   <= bin;
            scratch <= '0;
            count   <= CNT_W'(BIN_W);
            busy    <= 1'b1;
            state   <= SHIFT;
          end
        end

        SHIFT: begin
          // The thousands bit of the adjusted scratch is always 0 before the
          // final shift (the input is at most 10 bits), so dropping it here
          // loses nothing; the final shift moves bit 3 of the hundreds nibble
          // into it.
          {scratch, shreg} <= {adj2, adj1, adj0, shreg, 1'b0};
          count            <= count - CNT_W'(1);
          if (count == CNT_W'(1)) begin
            state <= COMMIT;
          end
        end

        COMMIT: begin
`ifdef BIN2BCD3_SATURATE_EN
          if (thous) begin
            a2 <= DIGIT_W'(9);
            a1 <= DIGIT_W'(9);
            a0 <= DIGIT_W'(9);
          end else begin
            a2 <= scratch[3*DIGIT_W-1:2*DIGIT_W];
            a1 <= scratch[2*DIGIT_W-1:DIGIT_W];
            a0 <= scratch[DIGIT_W-1:0];
          end
`else
          a2 <= scratch[3*DIGIT_W-1:2*DIGIT_W];
          a1 <= scratch[2*DIGIT_W-1:DIGIT_W];
          a0 <= scratch[DIGIT_W-1:0];
`endif
          ovf   <= thous;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd3_seq.sv
module tb_bin2bcd3_seq;
  import bin2bcd3_seq_pkg::*;

  localparam int BIN_W   = 10;
  localparam int LAT     = BIN_W + 1;
  localparam int MAXWAIT = 40;
`ifdef BIN2BCD3_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [BIN_W-1:0] bin;
  logic             busy;
  logic             done;
  logic [3:0]       a2;
  logic [3:0]       a1;
  logic [3:0]       a0;
  logic             ovf;

  int n_tests = 0;
  int n_fail  = 0;

  bin2bcd3_seq #(.BIN_W(BIN_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .a2    (a2),
    .a1    (a1),
    .a0    (a0),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int v;
    int e2;
    int e1;
    int e0;
    int eovf;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: decimal digits straight from the value by division.
  function automatic void model(input int v, output int d2, output int d1,
                                output int d0, output int o);
    int m;
    o = (v > BCD_MAX) ? 1 : 0;
    if (o == 1 && SAT) begin
      d2 = 9; d1 = 9; d0 = 9;
    end else begin
      m  = v % 1000;
      d2 = m / 100;
      d1 = (m / 10) % 10;
      d0 = m % 10;
    end
  endfunction

  // Called at a negedge with the DUT idle; returns at the negedge after E0.
  task automatic accept(input int v);
    start = 1'b1;
    bin   = BIN_W'(v);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check("busy_after_accept", busy, 1);
  endtask

  // Returns at the negedge of the done cycle (or after MAXWAIT cycles).
  task automatic wait_done(output int cyc);
    int busy_low = 0;
    cyc = -1;
    for (int k = 1; k <= MAXWAIT; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) begin
        cyc = k;
        break;
      end
      if (!busy) busy_low++;
    end
    check("busy_low_before_done", busy_low, 0);
    check("busy_in_done_cycle", busy, 0);
  endtask

  task automatic convert_and_check(input string tag, input int v, input int e2,
                                   input int e1, input int e0, input int eo);
    int lat;
    accept(v);
    wait_done(lat);
    check({tag, "_latency"}, lat, LAT);
    check({tag, "_digits"}, {a2, a1, a0}, {e2[3:0], e1[3:0], e0[3:0]});
    check({tag, "_ovf"}, ovf, eo);
  endtask

  initial begin
    vec_t vecs[$];
    int lat, ndone, changed, d2, d1, d0, o;
    logic [11:0] held;

    rst_n = 1'b0;
    start = 1'b0;
    bin   = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy",   busy, 0);
    check("reset_done",   done, 0);
    check("reset_digits", {a2, a1, a0}, 12'h000);
    check("reset_ovf",    ovf, 0);
    rst_n = 1'b1;
    @(negedge clk);

    vecs.push_back('{0,    0, 0, 0, 0});
    vecs.push_back('{512,  5, 1, 2, 0});
    vecs.push_back('{999,  9, 9, 9, 0});
    vecs.push_back('{1,    0, 0, 1, 0});
    vecs.push_back('{9,    0, 0, 9, 0});
    vecs.push_back('{10,   0, 1, 0, 0});
    vecs.push_back('{99,   0, 9, 9, 0});
    vecs.push_back('{100,  1, 0, 0, 0});
    vecs.push_back('{555,  5, 5, 5, 0});
`ifdef BIN2BCD3_SATURATE_EN
    vecs.push_back('{1023, 9, 9, 9, 1});
    vecs.push_back('{1000, 9, 9, 9, 1});
`else
    vecs.push_back('{1023, 0, 2, 3, 1});
    vecs.push_back('{1000, 0, 0, 0, 1});
`endif
    vecs.push_back('{0,    0, 0, 0, 0});

    foreach (vecs[i]) begin
      convert_and_check($sformatf("vec%0d_%0d", i, vecs[i].v), vecs[i].v,
                        vecs[i].e2, vecs[i].e1, vecs[i].e0, vecs[i].eovf);
    end

    for (int i = 0; i < 30; i++) begin
      int v;
      v = int'($urandom_range(0, 1023));
      model(v, d2, d1, d0, o);
      convert_and_check($sformatf("rnd_%0d", v), v, d2, d1, d0, o);
    end

    // start while busy is ignored; start in the done cycle is accepted
    repeat (2) @(negedge clk);
    accept(123);
    ndone = 0;
    lat   = -1;
    for (int c = 1; c <= MAXWAIT; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) begin
        ndone++;
        lat = c;
        break;
      end
      if (c >= 2 && c <= 7) begin
        start = 1'b1;
        bin   = BIN_W'(456);
      end else begin
        start = 1'b0;
      end
    end
    check("ignore_latency", lat, LAT);
    check("ignore_digits", {a2, a1, a0}, 12'h123);
    start = 1'b1;
    bin   = BIN_W'(456);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    bin   = BIN_W'(0);
    check("b2b_busy", busy, 1);
    wait_done(lat);
    check("b2b_latency", lat, LAT);
    check("b2b_digits", {a2, a1, a0}, 12'h456);
    repeat (4) begin
      @(posedge clk);
      @(negedge clk);
      if (done) ndone++;
    end
    check("single_done_after_b2b", ndone, 1);

    // reset during a conversion
    convert_and_check("pre_reset", 123, 1, 2, 3, 0);
    accept(777);
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_mid_busy",   busy, 0);
    check("rst_mid_done",   done, 0);
    check("rst_mid_digits", {a2, a1, a0}, 12'h000);
    check("rst_mid_ovf",    ovf, 0);
    ndone = 0;
    repeat (15) begin
      @(posedge clk);
      @(negedge clk);
      if (done) ndone++;
    end
    check("rst_mid_no_done", ndone, 0);
    convert_and_check("post_reset", 345, 3, 4, 5, 0);

    // digits hold while bin wiggles without start
    held    = {a2, a1, a0};
    ndone   = 0;
    changed = 0;
    for (int c = 0; c < 50; c++) begin
      bin = BIN_W'($urandom_range(0, 1023));
      @(posedge clk);
      @(negedge clk);
      if (done) ndone++;
      if ({a2, a1, a0} !== held) changed++;
    end
    check("hold_no_done", ndone, 0);
    check("hold_digits_changed", changed, 0);
    check("hold_digits", {a2, a1, a0}, 12'h345);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
